pu_msp430_pwm16: RTL and testbench
==================================

# pu_msp430_pwm16

Double-buffered 16-bit PWM generator that consumes two control words of the 16-bit template peripheral (`cntrl2_16b` as period, `cntrl4_16b` as duty) and drives a pin-level PWM output plus a period interrupt. It sits directly downstream of the register-file peripheral in the MSP430 peripheral subsystem, in the `mclk` domain. Period and duty changes take effect only at a period boundary, so software writes never produce truncated or runt pulses.

## Interface
Parameters:
- `CNT_WD`, 16, width of the period/duty counter and of `period_16b`/`duty_16b`.
- `PRESC_WD`, 8, width of the prescaler divider input and counter.

Ports:
- `mclk`  in  1  main system clock.
- `puc_rst`  in  1  reset, synchronous, active-high.
- `pwm_en`  in  1  run enable, level-sensitive.
- `period_16b`  in  CNT_WD  period word, from `cntrl2_16b`.
- `duty_16b`  in  CNT_WD  duty word, from `cntrl4_16b`.
- `presc`  in  PRESC_WD  prescale divider; one tick every `presc`+1 cycles.
- `irq_ack`  in  1  single-cycle pulse that clears `pwm_irq` and `pwm_ovf`.
- `pwm_out`  out  1  registered PWM output.
- `pwm_irq`  out  1  period-wrap interrupt, sticky.
- `pwm_ovf`  out  1  overrun: a wrap occurred while `pwm_irq` was already set, sticky.
- `cnt_val`  out  CNT_WD  current counter value.

## Operation
- Reset (`puc_rst`=1 at a rising edge) sets: state=IDLE, `cnt`=0, prescaler count=0, shadow period/duty=0, `pwm_out`=0, `pwm_irq`=0, `pwm_ovf`=0. `cnt_val` therefore reads 0.
- Reset overrides every other input, including mid-period.
- FSM states are IDLE, LOAD and RUN.
  - IDLE: counters are held at 0. If `pwm_en`=1, go to LOAD.
  - LOAD (one cycle): latch shadow_period←`period_16b` and shadow_duty←`duty_16b`; clear `cnt` and the prescaler; go to RUN. If `pwm_en`=0, go to IDLE instead and load nothing.
  - RUN, when `pwm_en`=0: go to IDLE and clear `cnt` and the prescaler. Shadows are kept.
- RUN counting:
  - The prescaler increments each cycle. When it equals `presc`, it clears and asserts `tick` for that cycle.
  - On `tick` with `cnt`≠shadow_period: `cnt`←`cnt`+1.
  - On `tick` with `cnt`=shadow_period (wrap):
    - `cnt`←0.
    - Reload shadows from `period_16b`/`duty_16b`.
    - Set `pwm_irq`.
    - Set `pwm_ovf` if `pwm_irq` was already 1.
- Output rule: `pwm_out` at the next edge = (state=RUN) & (`cnt` < shadow_duty). The comparison is unsigned at CNT_WD width.
- Duty and period rules:
  - duty=0: `pwm_out` stays 0.
  - duty > period: `pwm_out` stays 1 throughout RUN.
  - period=0: `cnt` stays 0 and a wrap occurs on every tick.
- Interrupt rules:
  - `irq_ack` clears `pwm_irq` and `pwm_ovf`.
  - If a wrap and `irq_ack` occur in the same cycle, set wins: `pwm_irq`=1 and `pwm_ovf` is unchanged.
  - `pwm_irq` and `pwm_ovf` are unaffected by `pwm_en`.
- Changes to `period_16b`, `duty_16b` or `presc` during RUN:
  - Period and duty are invisible until the next wrap.
  - `presc` is compared live.

## Timing
- Period length = (shadow_period+1)·(`presc`+1) cycles. High time = min(shadow_duty, shadow_period+1)·(`presc`+1) cycles.
- Start-up sequence:
  - `pwm_en` sampled 1 in IDLE at edge k → state=LOAD after edge k.
  - After edge k+1: RUN, `cnt`=0.
  - First `pwm_out`=1 after edge k+2 (if duty>0).
- `pwm_out` lags `cnt` by exactly one cycle. `pwm_irq` rises at the edge where `cnt` wraps to 0.
- Stop sequence: `pwm_en` sampled 0 in RUN at edge j → IDLE after edge j; `pwm_out` is 0 after edge j+1. It may still be 1 for the single cycle between edges j and j+1.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Package `pu_msp430_pwm_pkg`: state enum typedef `pwm_state_t` (IDLE, LOAD, RUN) and localparam defaults for CNT_WD and PRESC_WD.
- Sub-module `pu_msp430_pwm_prescaler`: PRESC_WD counter with inputs `clr`, `presc` and output `tick`. It clears synchronously on `puc_rst` or `clr`.
- Top level contains the FSM, the counter, the shadow registers, the output flop and the interrupt flags.

## Test plan
- Reset mid-RUN: assert `puc_rst` one cycle while `pwm_out`=1 and `cnt`=3 → next edge: `pwm_out`=0, `cnt_val`=0, `pwm_irq`=0, state IDLE.
- Basic waveform: period=4, duty=2, `presc`=0, `pwm_en`=1 → `pwm_out` repeats 2 cycles high / 3 low (5-cycle period); `pwm_irq` sets at the first wrap, 5 cycles after RUN entry.
- Prescale: period=1, duty=1, `presc`=2 → 6-cycle period with 3 cycles high; `cnt_val` steps once every 3 cycles.
- Double buffering: in RUN with period=9, write duty 3→7 at `cnt`=2 → the current period keeps 3 high ticks; the period after the next wrap shows 7 high ticks.
- Edge duty and period values:
  - duty=0 → `pwm_out` constantly 0.
  - duty=20 with period=9 → constantly 1.
  - period=0 with `presc`=0 → `pwm_irq` re-sets every cycle; `pwm_ovf` sets on the second wrap if `pwm_irq` was not acked.
- Interrupt handshake: `irq_ack` pulse in a non-wrap cycle clears `pwm_irq` and `pwm_ovf`; `irq_ack` coincident with a wrap leaves `pwm_irq`=1.

Source files
------------

// File: rtl/pu_msp430_pwm_pkg.sv
// Shared types and default widths for the double-buffered 16-bit PWM block.
package pu_msp430_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } pwm_state_t;

    localparam int CNT_WD_DEF   = 16;
    localparam int PRESC_WD_DEF = 8;

endpackage

// File: rtl/pu_msp430_pwm_prescaler.sv
// Clock prescaler: emits one tick every presc+1 cycles while not cleared.
// presc is compared live, so a new divider takes effect on the next match.
module pu_msp430_pwm_prescaler
    import pu_msp430_pwm_pkg::*;
#(
    parameter int PRESC_WD = PRESC_WD_DEF
) (
    input  logic                mclk,
    input  logic                puc_rst,
    input  logic                clr,
    input  logic [PRESC_WD-1:0] presc,
    output logic                tick
);

    logic [PRESC_WD-1:0] pcnt;

    // A tick is only meaningful while the prescaler is running.
    assign tick = ~clr & (pcnt == presc);

    // Divider counter: restarts on reset/clear and after every match.
    always_ff @(posedge mclk) begin
        if (puc_rst || clr) begin
            pcnt <= '0;
        end else if (pcnt == presc) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESC_WD'(1);
        end
    end

endmodule

// File: rtl/pu_msp430_pwm16.sv
// Double-buffered PWM generator driven by the 16-bit template peripheral.
// Period/duty are captured into shadow registers at start-up and at every
// period wrap, so software writes never cut a pulse short.
module pu_msp430_pwm16
    import pu_msp430_pwm_pkg::*;
#(
    parameter int CNT_WD   = CNT_WD_DEF,
    parameter int PRESC_WD = PRESC_WD_DEF
) (
    input  logic                mclk,
    input  logic                puc_rst,
    input  logic                pwm_en,
    input  logic [CNT_WD-1:0]   period_16b,
    input  logic [CNT_WD-1:0]   duty_16b,
    input  logic [PRESC_WD-1:0] presc,
    input  logic                irq_ack,
    output logic                pwm_out,
    output logic                pwm_irq,
    output logic                pwm_ovf,
    output logic [CNT_WD-1:0]   cnt_val
);

    pwm_state_t        state;
    pwm_state_t        state_nxt;
    logic [CNT_WD-1:0] cnt;
    logic [CNT_WD-1:0] shadow_period;
    logic [CNT_WD-1:0] shadow_duty;
    logic              run_en;
    logic              presc_clr;
    logic              tick;
    logic              wrap;

    // Counting happens only in RUN with the enable still high; anything
    // else holds the prescaler (and the counter) at zero.
    assign run_en    = (state == RUN) && pwm_en;
    assign presc_clr = ~run_en;
    assign wrap      = tick && (cnt == shadow_period);
    assign cnt_val   = cnt;

    pu_msp430_pwm_prescaler #(
        .PRESC_WD (PRESC_WD)
    ) u_presc (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .clr     (presc_clr),
        .presc   (presc),
        .tick    (tick)
    );

    // FSM state register.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: enable starts via a one-cycle LOAD, dropping it stops.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pwm_en) state_nxt = LOAD;
            LOAD:    state_nxt = pwm_en ? RUN : IDLE;
            RUN:     if (!pwm_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Period counter and shadow registers; shadows reload only at LOAD or wrap.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            cnt           <= '0;
            shadow_period <= '0;
            shadow_duty   <= '0;
        end else if ((state == LOAD) && pwm_en) begin
            cnt           <= '0;
            shadow_period <= period_16b;
            shadow_duty   <= duty_16b;
        end else if (!run_en) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt           <= '0;
            shadow_period <= period_16b;
            shadow_duty   <= duty_16b;
        end else if (tick) begin
            cnt <= cnt + CNT_WD'(1);
        end
    end

    // Registered output compare; lags the counter by one cycle.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (state == RUN) && (cnt < shadow_duty);
        end
    end

    // Sticky interrupt/overrun flags; a wrap beats a coincident acknowledge.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            pwm_irq <= 1'b0;
            pwm_ovf <= 1'b0;
        end else if (wrap) begin
            pwm_irq <= 1'b1;
            if (!irq_ack) begin
                pwm_ovf <= pwm_ovf | pwm_irq;
            end
        end else if (irq_ack) begin
            pwm_irq <= 1'b0;
            pwm_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pu_msp430_pwm16.sv
// Self-checking bench for pu_msp430_pwm16: a cycle model pushes the expected
// outputs for each edge into a queue, which is popped and compared after it.
module tb_pu_msp430_pwm16;

    logic        mclk;
    logic        puc_rst;
    logic        pwm_en;
    logic [15:0] period_16b;
    logic [15:0] duty_16b;
    logic [7:0]  presc;
    logic        irq_ack;
    logic        pwm_out;
    logic        pwm_irq;
    logic        pwm_ovf;
    logic [15:0] cnt_val;

    typedef struct {
        logic        out;
        logic        irq;
        logic        ovf;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (0=IDLE, 1=LOAD, 2=RUN).
    int          m_state;
    logic [15:0] m_cnt;
    logic [7:0]  m_pre;
    logic [15:0] m_sp;
    logic [15:0] m_sd;
    logic        m_out;
    logic        m_irq;
    logic        m_ovf;

    pu_msp430_pwm16 dut (
        .mclk       (mclk),
        .puc_rst    (puc_rst),
        .pwm_en     (pwm_en),
        .period_16b (period_16b),
        .duty_16b   (duty_16b),
        .presc      (presc),
        .irq_ack    (irq_ack),
        .pwm_out    (pwm_out),
        .pwm_irq    (pwm_irq),
        .pwm_ovf    (pwm_ovf),
        .cnt_val    (cnt_val)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_next();
        logic n_out;
        logic tk;
        logic wrp;
        if (puc_rst) begin
            m_state = 0; m_cnt = 0; m_pre = 0; m_sp = 0; m_sd = 0;
            m_out = 0; m_irq = 0; m_ovf = 0;
            return;
        end
        n_out = (m_state == 2) && (m_cnt < m_sd);
        wrp = 1'b0;
        case (m_state)
            0: begin
                m_cnt = 0; m_pre = 0;
                if (pwm_en) m_state = 1;
            end
            1: begin
                m_cnt = 0; m_pre = 0;
                if (pwm_en) begin
                    m_sp = period_16b; m_sd = duty_16b; m_state = 2;
                end else begin
                    m_state = 0;
                end
            end
            default: begin
                if (!pwm_en) begin
                    m_state = 0; m_cnt = 0; m_pre = 0;
                end else begin
                    tk = (m_pre == presc);
                    m_pre = tk ? 8'd0 : m_pre + 8'd1;
                    if (tk) begin
                        if (m_cnt == m_sp) begin
                            wrp = 1'b1;
                            m_cnt = 0; m_sp = period_16b; m_sd = duty_16b;
                        end else begin
                            m_cnt = m_cnt + 16'd1;
                        end
                    end
                end
            end
        endcase
        if (wrp) begin
            if (!irq_ack) m_ovf = m_ovf | m_irq;
            m_irq = 1'b1;
        end else if (irq_ack) begin
            m_irq = 1'b0; m_ovf = 1'b0;
        end
        m_out = n_out;
    endtask

    // One clock: push expectation, wait for the edge, pop and compare.
    task automatic step();
        exp_t e;
        model_next();
        e.out = m_out; e.irq = m_irq; e.ovf = m_ovf; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge mclk);
        #1;
        e = sb_q.pop_front();
        check_eq("pwm_out", {31'd0, pwm_out}, {31'd0, e.out});
        check_eq("pwm_irq", {31'd0, pwm_irq}, {31'd0, e.irq});
        check_eq("pwm_ovf", {31'd0, pwm_ovf}, {31'd0, e.ovf});
        check_eq("cnt_val", {16'd0, cnt_val}, {16'd0, e.cnt});
    endtask

    task automatic start_run();
        pwm_en = 1'b1;
        step();
        step();
    endtask

    task automatic stop_run();
        pwm_en = 1'b0;
        step();
        step();
    endtask

    task automatic count_high(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (pwm_out) highs++;
        end
    endtask

    initial begin
        int highs;
        int first_irq;
        int guard;

        puc_rst = 1'b1; pwm_en = 1'b0; irq_ack = 1'b0;
        period_16b = 16'd0; duty_16b = 16'd0; presc = 8'd0;
        step();
        step();
        puc_rst = 1'b0;
        check_eq("rst_cnt", {16'd0, cnt_val}, 32'd0);
        check_eq("rst_out", {31'd0, pwm_out}, 32'd0);

        // Basic waveform: 5-cycle period, 2 high.
        period_16b = 16'd4; duty_16b = 16'd2; presc = 8'd0;
        start_run();
        first_irq = -1;
        highs = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (pwm_out) highs++;
            if (pwm_irq && first_irq < 0) first_irq = i;
        end
        check_eq("basic_high", highs, 4);
        check_eq("basic_first_irq", first_irq, 5);

        // Prescale: 6-cycle period, 3 high.
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        stop_run();
        period_16b = 16'd1; duty_16b = 16'd1; presc = 8'd2;
        start_run();
        count_high(12, highs);
        check_eq("presc_high", highs, 6);

        // Double buffering: duty write mid-period waits for the wrap.
        stop_run();
        period_16b = 16'd9; duty_16b = 16'd3; presc = 8'd0;
        start_run();
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) duty_16b = 16'd7;
            step();
            if (pwm_out) highs++;
        end
        check_eq("dbuf_old_high", highs, 3);
        count_high(10, highs);
        check_eq("dbuf_new_high", highs, 7);

        // duty=0 never drives high.
        stop_run();
        period_16b = 16'd4; duty_16b = 16'd0;
        start_run();
        count_high(12, highs);
        check_eq("duty0_high", highs, 0);

        // duty > period stays high throughout RUN.
        stop_run();
        period_16b = 16'd9; duty_16b = 16'd20;
        start_run();
        count_high(12, highs);
        check_eq("duty20_high", highs, 12);

        // Reset mid-RUN while pwm_out=1 and cnt=3.
        guard = 0;
        while (cnt_val != 16'd3 && guard < 40) begin
            step();
            guard++;
        end
        check_eq("wait_cnt3", {16'd0, cnt_val}, 32'd3);
        check_eq("pre_rst_out", {31'd0, pwm_out}, 32'd1);
        check_eq("pre_rst_irq", {31'd0, pwm_irq}, 32'd1);
        puc_rst = 1'b1; pwm_en = 1'b0;
        step();
        puc_rst = 1'b0;
        check_eq("midrst_out", {31'd0, pwm_out}, 32'd0);
        check_eq("midrst_cnt", {16'd0, cnt_val}, 32'd0);
        check_eq("midrst_irq", {31'd0, pwm_irq}, 32'd0);

        // period=0: wrap on every tick, overrun on the second unacked wrap.
        period_16b = 16'd0; duty_16b = 16'd0; presc = 8'd0;
        start_run();
        step();
        check_eq("p0_irq1", {31'd0, pwm_irq}, 32'd1);
        check_eq("p0_ovf1", {31'd0, pwm_ovf}, 32'd0);
        step();
        check_eq("p0_ovf2", {31'd0, pwm_ovf}, 32'd1);

        // Interrupt handshake.
        stop_run();
        period_16b = 16'd4; duty_16b = 16'd2;
        start_run();
        check_eq("irq_sticky", {31'd0, pwm_irq}, 32'd1);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        check_eq("ack_irq", {31'd0, pwm_irq}, 32'd0);
        check_eq("ack_ovf", {31'd0, pwm_ovf}, 32'd0);
        guard = 0;
        while (cnt_val != 16'd4 && guard < 20) begin
            step();
            guard++;
        end
        check_eq("wait_cnt4", {16'd0, cnt_val}, 32'd4);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        check_eq("ack_wrap_irq", {31'd0, pwm_irq}, 32'd1);
        check_eq("ack_wrap_ovf", {31'd0, pwm_ovf}, 32'd0);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
